// File: rtl/snn_inference_ctrl_if.sv
// Host, input-stream and if_network signals of snn_inference_ctrl.
// master drives the host and network-output side; slave is the controller.
interface snn_inference_ctrl_if #(
  parameter int unsigned NUM_INPUTS  = 1,
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned CNT_WIDTH   = 8
);
  localparam int unsigned WinW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  logic                             start;
  logic                             abort;
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_INPUTS-1:0]            in_spikes;
  logic                             net_rst;
  logic                             net_step;
  logic [NUM_INPUTS-1:0]            net_spike_in;
  logic [NUM_OUTPUTS-1:0]           net_spike_out;
  logic                             busy;
  logic                             result_valid;
  logic                             result_ready;
  logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_counts;
  logic [WinW-1:0]                  winner;
  logic                             winner_valid;

  modport master (
    output start, abort, in_valid, in_spikes, result_ready, net_spike_out,
    input  in_ready, net_rst, net_step, net_spike_in, busy, result_valid,
           spike_counts, winner, winner_valid
  );

  modport slave (
    input  start, abort, in_valid, in_spikes, result_ready, net_spike_out,
    output in_ready, net_rst, net_step, net_spike_in, busy, result_valid,
           spike_counts, winner, winner_valid
  );
endinterface

// File: rtl/snn_inference_ctrl.sv
// Runs one inference through if_network: clear, NUM_STEPS accepted timesteps, drain,
// then hold saturating per-neuron spike counts and the winning index for the host.
module snn_inference_ctrl #(
  parameter int unsigned NUM_INPUTS  = 1,
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned NUM_STEPS   = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned NET_LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  snn_inference_ctrl_if.slave bus
);
  localparam int unsigned WinW  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int unsigned StepW = $clog2(NUM_STEPS + 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

  state_e                           state_q, state_d;
  logic [StepW-1:0]                 step_q, step_d;
  logic                             net_step_q, net_step_d;
  logic [NUM_INPUTS-1:0]            net_spike_in_q, net_spike_in_d;
  logic                             net_rst_q, net_rst_d;
  logic [NET_LATENCY-1:0]           pipe_q, pipe_d;
  logic [NUM_OUTPUTS*CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WinW-1:0]                  winner_q, winner_d;
  logic                             winner_valid_q, winner_valid_d;

  logic [NET_LATENCY:0] chain;
  logic                 accept;
  logic                 clear;
  logic [CNT_WIDTH-1:0] cur;
  logic [CNT_WIDTH-1:0] best;

  // chain[0] is the step issued this cycle; chain[NET_LATENCY] marks net_spike_out as valid.
  assign chain  = {pipe_q, net_step_q};
  assign accept = (state_q == StRun) && bus.in_valid && !bus.abort;
  assign clear  = ((state_q == StIdle) && bus.start) || ((state_q != StIdle) && bus.abort);

  always_comb begin
    state_d        = state_q;
    step_d         = accept ? step_q + StepW'(1) : step_q;
    net_step_d     = accept;
    net_spike_in_d = accept ? bus.in_spikes : '0;
    net_rst_d      = clear;
    pipe_d         = chain[NET_LATENCY-1:0];
    cnt_d          = cnt_q;
    cur            = '0;

    unique case (state_q)
      StIdle:  if (bus.start) state_d = StClear;
      StClear: state_d = StRun;
      StRun:   if (accept && (step_q == StepW'(NUM_STEPS - 1))) state_d = StDrain;
      StDrain: if (chain[NET_LATENCY-1:0] == '0) state_d = StDone;
      StDone:  if (bus.result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && bus.abort) state_d = StIdle;

    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      cur = cnt_q[i*CNT_WIDTH +: CNT_WIDTH];
      if (chain[NET_LATENCY] && bus.net_spike_out[i] && (cur != CntMax)) begin
        cur = cur + CNT_WIDTH'(1);
      end
      cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cur;
    end

    if (clear) begin
      step_d = '0;
      pipe_d = '0;
      cnt_d  = '0;
    end
  end

  // Winner tracks the next counts so it is always consistent with spike_counts.
  always_comb begin
    best     = '0;
    winner_d = '0;
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (cnt_d[i*CNT_WIDTH +: CNT_WIDTH] > best) begin
        best     = cnt_d[i*CNT_WIDTH +: CNT_WIDTH];
        winner_d = WinW'(i);
      end
    end
    winner_valid_d = (best != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      step_q         <= '0;
      net_step_q     <= 1'b0;
      net_spike_in_q <= '0;
      net_rst_q      <= 1'b0;
      pipe_q         <= '0;
      cnt_q          <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      net_step_q     <= net_step_d;
      net_spike_in_q <= net_spike_in_d;
      net_rst_q      <= net_rst_d;
      pipe_q         <= pipe_d;
      cnt_q          <= cnt_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
    end
  end

  assign bus.in_ready     = (state_q == StRun);
  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StDone);
  assign bus.net_rst      = net_rst_q;
  assign bus.net_step     = net_step_q;
  assign bus.net_spike_in = net_spike_in_q;
  assign bus.spike_counts = cnt_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Randomised bench for snn_inference_ctrl against an inference-level reference model,
// with a delayed-identity network model that injects noise on non-step cycles.
module tb_snn_inference_ctrl;
  localparam int unsigned NI = 3;
  localparam int unsigned NO = 3;
  localparam int unsigned NS = 10;
  localparam int unsigned CW = 3;
  localparam int unsigned L  = 2;
  localparam int unsigned WW = 2;
  localparam int          CMAX = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_inference_ctrl_if #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .CNT_WIDTH(CW)) bus ();

  snn_inference_ctrl #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .NUM_STEPS  (NS),
    .CNT_WIDTH  (CW),
    .NET_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (inference level) ----------------
  bit                m_init = 0;
  bit                m_active = 0;
  bit                m_known = 1;
  int                m_cyc = 0, m_acc = 0, m_last = 0;
  int                m_sum [NO];
  logic              exp_busy, exp_in_ready, exp_net_rst, exp_net_step, exp_result_valid, exp_wv;
  logic [NI-1:0]     exp_spk_in;
  logic [NO*CW-1:0]  exp_counts;
  logic [WW-1:0]     exp_winner;

  always @(posedge clk) begin
    bit ready_now, done_now;
    int sat [NO];
    int mx;
    ready_now = m_active && (m_cyc >= 2) && (m_acc < NS);
    done_now  = m_active && (m_acc == NS) && (m_cyc >= m_last + L + 2);
    exp_net_rst  = 1'b0;
    exp_net_step = 1'b0;
    exp_spk_in   = '0;
    if (rst) begin
      m_active = 0;
      foreach (m_sum[i]) m_sum[i] = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1; m_cyc = 1; m_acc = 0; exp_net_rst = 1'b1;
        foreach (m_sum[i]) m_sum[i] = 0;
      end
    end else if (bus.abort) begin
      m_active = 0; exp_net_rst = 1'b1;
      foreach (m_sum[i]) m_sum[i] = 0;
    end else if (done_now && bus.result_ready) begin
      m_active = 0;
    end else begin
      if (ready_now && bus.in_valid) begin
        m_acc++;
        m_last = m_cyc;
        foreach (m_sum[i]) m_sum[i] += int'(bus.in_spikes[i]);
        exp_net_step = 1'b1;
        exp_spk_in   = bus.in_spikes;
      end
      m_cyc++;
    end
    exp_busy         = m_active;
    exp_in_ready     = m_active && (m_cyc >= 2) && (m_acc < NS);
    exp_result_valid = m_active && (m_acc == NS) && (m_cyc >= m_last + L + 2);
    m_known          = !m_active || (m_cyc == 1) || exp_result_valid;
    // Saturated totals; winner is the first neuron reaching the maximum.
    mx = 0;
    foreach (sat[i]) begin
      sat[i] = (m_sum[i] > CMAX) ? CMAX : m_sum[i];
      exp_counts[i*CW +: CW] = sat[i][CW-1:0];
      if (sat[i] > mx) mx = sat[i];
    end
    exp_winner = '0;
    for (int i = NO - 1; i >= 0; i--) if (sat[i] == mx) exp_winner = WW'(i);
    exp_wv = (mx > 0);
    m_init = 1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("busy", bus.busy, exp_busy);
      check("in_ready", bus.in_ready, exp_in_ready);
      check("net_rst", bus.net_rst, exp_net_rst);
      check("net_step", bus.net_step, exp_net_step);
      check("net_spike_in", bus.net_spike_in, exp_spk_in);
      check("result_valid", bus.result_valid, exp_result_valid);
      if (m_known) begin
        check("spike_counts", bus.spike_counts, exp_counts);
        check("winner", bus.winner, exp_winner);
        check("winner_valid", bus.winner_valid, exp_wv);
      end
    end
  end

  // ---------------- network model: output = input delayed by L, noise otherwise ----------------
  logic [NI-1:0] h_spk  [L+1];
  logic          h_step [L+1];
  int            step_pulses = 0;

  always @(posedge clk) begin
    #1;
    for (int k = L; k > 0; k--) begin
      h_spk[k]  = h_spk[k-1];
      h_step[k] = h_step[k-1];
    end
    h_step[0] = bus.net_step;
    h_spk[0]  = bus.net_spike_in;
    if (bus.net_step === 1'b1) step_pulses++;
    bus.net_spike_out = (h_step[L] === 1'b1) ? h_spk[L] : NO'($urandom);
  end

  // ---------------- driver ----------------
  logic [NI-1:0] vec [NS+1];
  logic [NI-1:0] pat_tbl [NS];

  // pat: 0 table, 1 all ones, 2 all zero, 3 random. vmode: 0 always, 1 toggle, 2 random.
  task automatic run_inf(input int pat, input int vmode, input int hold,
                         input int abort_at, input int rst_at);
    int  held;
    bit  ended;
    bit  consumed;
    int  cyc;
    for (int i = 0; i < NS; i++) begin
      case (pat)
        0:       vec[i] = pat_tbl[i];
        1:       vec[i] = '1;
        2:       vec[i] = '0;
        default: vec[i] = NI'($urandom);
      endcase
    end
    vec[NS] = '0;
    bus.start = 1'b1;
    bus.abort = 1'($urandom_range(0, 1));
    @(posedge clk); #2;
    held = 0; ended = 0;
    for (cyc = 0; cyc < 400 && !ended; cyc++) begin
      bus.abort        = 1'b0;
      rst              = 1'b0;
      bus.in_valid     = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) :
                         1'($urandom_range(0, 1));
      bus.in_spikes    = bus.in_valid ? vec[m_acc] : NI'($urandom);
      consumed         = 0;
      if (bus.result_valid) begin
        bus.start        = (held == 3);
        bus.result_ready = (held >= hold);
        consumed         = (held >= hold);
        held++;
      end else begin
        bus.start        = ($urandom_range(0, 7) == 0);
        bus.result_ready = ($urandom_range(0, 3) == 0);
      end
      if (abort_at >= 0 && m_active && m_acc == abort_at) begin
        bus.abort = 1'b1; abort_at = -1; consumed = 1;
      end
      if (rst_at >= 0 && m_active && m_acc == rst_at) begin
        rst = 1'b1; rst_at = -1; consumed = 1;
      end
      @(posedge clk); #2;
      ended = consumed;
    end
    if (!ended) begin
      bad++; total++;
      $display("FAIL timeout: inference did not finish within 400 cycles");
    end
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.result_ready = 0; rst = 0;
  endtask

  task automatic pin(input string name, input logic [NO*CW-1:0] cnt, input int win, input bit wv);
    check({name, "_counts"}, bus.spike_counts, cnt);
    check({name, "_winner"}, bus.winner, WW'(win));
    check({name, "_winner_valid"}, bus.winner_valid, wv);
  endtask

  initial begin
    logic [NO*CW-1:0] pat_cnt, sat_cnt;
    pat_cnt = {3'd5, 3'd5, 3'd2};
    sat_cnt = {3'd7, 3'd7, 3'd7};
    for (int i = 0; i < NS; i++) pat_tbl[i] = (i < 2) ? 3'b111 : (i < 5) ? 3'b110 : 3'b000;
    rst = 1'b1;
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_spikes = '0;
    bus.result_ready = 0; bus.net_spike_out = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    check("reset_busy", bus.busy, 0);
    check("reset_net_step", bus.net_step, 0);
    pin("reset", '0, 0, 0);

    run_inf(0, 0, 0, -1, -1);
    pin("pattern", pat_cnt, 1, 1);

    step_pulses = 0;
    run_inf(0, 1, 2, -1, -1);
    pin("stall", pat_cnt, 1, 1);
    check("stall_step_pulses", step_pulses, NS);

    run_inf(1, 2, 1, -1, -1);
    pin("saturate", sat_cnt, 0, 1);

    run_inf(2, 2, 0, -1, -1);
    pin("silent", '0, 0, 0);

    run_inf(3, 2, 0, 2, -1);
    check("abort_net_rst", bus.net_rst, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_result_valid", bus.result_valid, 0);
    pin("abort", '0, 0, 0);
    @(posedge clk); #2;
    run_inf(0, 0, 0, -1, -1);
    pin("after_abort", pat_cnt, 1, 1);

    run_inf(0, 0, 10, -1, -1);
    pin("hold", pat_cnt, 1, 1);

    run_inf(3, 2, 0, -1, 3);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_net_step", bus.net_step, 0);
    pin("rst_mid", '0, 0, 0);

    for (int r = 0; r < 8; r++) run_inf(3, 2, $urandom_range(0, 4), -1, -1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
